fp_wb_arbiter: RTL and testbench
================================

# fp_wb_arbiter

Parametrised writeback merge stage for the FPU. It collects results from `NUM_WB_UNITS` floating-point producer channels (FMA, FMUL, FDIV/FSQRT, WB2FP and any later additions), arbitrates between them, and buffers the winners in a small FIFO. It presents one writeback request to the FP register-file writeback port. It also merges the exception flags of accepted FP writebacks with those of the integer-destination FPU path in the same cycle.

## Interface
Parameters:
- `NUM_WB_UNITS`, 4: number of producer channels, 2..8.
- `DATA_WIDTH`, 64: result width (FLEN).
- `ID_WIDTH`, 3: instruction ID width.
- `FIFO_DEPTH`, 2: output buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `unit_done`  in  NUM_WB_UNITS: channel i holds a valid result.
- `unit_rd`  in  NUM_WB_UNITS×DATA_WIDTH: channel result data.
- `unit_id`  in  NUM_WB_UNITS×ID_WIDTH: channel instruction ID.
- `unit_fflags`  in  NUM_WB_UNITS×5: channel flags {NV,DZ,OF,UF,NX}.
- `unit_ack`  out  NUM_WB_UNITS: one-hot grant; channel i's result is consumed this cycle.
- `wb_done`  out  1: FIFO head valid.
- `wb_rd`  out  DATA_WIDTH: head data.
- `wb_id`  out  ID_WIDTH: head ID.
- `wb_ack`  in  1: writeback accepted the head.
- `int_accepted`  in  1: the integer-destination FPU path completed a writeback this cycle.
- `int_fflags`  in  5: flags of that integer writeback.
- `fflags`  out  5: flags to OR into fcsr this cycle.

## Operation
- Space condition: `space = ~full | (wb_done & wb_ack)`. A push is therefore permitted in the same cycle as a pop when the FIFO is full.
- Grant:
  - When `space` is high and any `unit_done` bit is set, exactly one `unit_ack` bit goes high, combinationally, in the same cycle.
  - When `space` is low, `unit_ack` is all zeros.
- Arbitration uses a round-robin pointer `rr_ptr` (clog2(NUM_WB_UNITS) bits).
  - Search starts at `rr_ptr` and proceeds upward, wrapping modulo NUM_WB_UNITS.
  - After a grant to channel g, `rr_ptr` becomes (g+1) mod NUM_WB_UNITS.
  - With no grant, `rr_ptr` holds.
- Push: the granted channel's {rd, id, fflags} are written at the tail on the clock edge.
- Pop: the head advances when `wb_done & wb_ack`. `wb_ack` while `wb_done` is low is ignored.
- Occupancy:
  - Tracked by a count of 0..FIFO_DEPTH, with read and write pointers that wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop leaves the count unchanged.
  - A push into a FIFO that is full without a concurrent pop cannot happen by construction.
- FIFO ordering: entries leave in grant order. Write-after-write ordering is handled upstream by ID tracking.
- Flags: let `fp_acc = wb_done & wb_ack`, with `head_fflags` the flags of the head entry.
  - `fp_acc & int_accepted`: `fflags = head_fflags | int_fflags`.
  - `fp_acc` only: `fflags = head_fflags`.
  - `int_accepted` only: `fflags = int_fflags`.
  - Neither: `fflags = 0`.
- Reset: FIFO emptied (count = 0, both pointers = 0) and `rr_ptr = 0`.
- Reset mid-operation: buffered results are discarded, and `unit_ack` is forced to 0 during the reset cycle.

## Timing
- Reset values: `wb_done = 0`, `unit_ack = 0`, `fflags = 0` (given `int_accepted = 0`). `wb_rd` and `wb_id` are don't-care while `wb_done = 0`.
- Latency:
  - A `unit_ack` in cycle t into an empty FIFO gives `wb_done = 1` in cycle t+1 with that entry's data.
  - There is no bypass, so the minimum latency is 1.
- Throughput: one grant and one pop per cycle, sustained, with any FIFO_DEPTH ≥ 2.
- Combinational paths:
  - `unit_ack` depends on `unit_done`, `wb_ack` and state.
  - `fflags` depends on `wb_ack`, `int_accepted` and `int_fflags`.
  - `wb_done`, `wb_rd` and `wb_id` are register-driven only.
- A producer channel holds `unit_done` and its data stable until it sees `unit_ack`.

## Configuration
- Macro `FP_WB_ROUND_ROBIN_EN`:
  - Defined: round-robin arbitration as described.
  - Undefined: fixed priority, where the lowest index wins. `rr_ptr` is not implemented, and everything else is identical.

## Test plan
- **Reset**: assert `rst` with `unit_done = 4'b1111`. Required: `unit_ack = 0`, `wb_done = 0` and `fflags = 0` throughout. After release, the first grant goes to channel 0.
- **Single result**: `unit_done[2] = 1` with rd = 64'h4000_0000_0000_0000, id = 5, fflags = 5'b00001, and `wb_ack` tied high.
  - `unit_ack = 4'b0100` in cycle t.
  - In cycle t+1: `wb_done = 1`, `wb_id = 5`, `fflags = 5'b00001`.
- **Round-robin fairness**: hold all four `unit_done` high and tie `wb_ack` to 1. Required grant sequence 0,1,2,3,0. Without the macro, channel 0 is granted every cycle.
- **Full and backpressure** (FIFO_DEPTH = 2):
  - Hold `wb_ack = 0` and grant twice; `unit_ack` must then be 0.
  - Raise `wb_ack`: a grant and a pop occur in the same cycle, and the count stays at 2.
- **Simultaneous flags**: head fflags = 5'b10000 popped in the same cycle as `int_accepted = 1` with `int_fflags = 5'b00101`. Required `fflags = 5'b10101`.
- **Wrap-around**: push and pop 7 entries with IDs 0..6 through a depth-2 FIFO under random `wb_ack`. The IDs must emerge in the order 0..6 with no loss or duplication.

Source files
------------

// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: FPU writeback merge stage.
// Arbitrates NUM_WB_UNITS producer channels into a small result FIFO that feeds
// the FP register-file writeback port, and merges the exception flags of the
// popped FP result with those of the integer-destination FPU path.
// Optional feature macro: FP_WB_ROUND_ROBIN_EN (defined = round-robin
// arbitration, undefined = fixed priority with the lowest index winning).
module fp_wb_arbiter #(
  parameter int NUM_WB_UNITS = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int ID_WIDTH     = 3,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_WB_UNITS-1:0]            unit_done,
  input  logic [NUM_WB_UNITS*DATA_WIDTH-1:0] unit_rd,
  input  logic [NUM_WB_UNITS*ID_WIDTH-1:0]   unit_id,
  input  logic [NUM_WB_UNITS*5-1:0]          unit_fflags,
  output logic [NUM_WB_UNITS-1:0]            unit_ack,
  output logic                               wb_done,
  output logic [DATA_WIDTH-1:0]              wb_rd,
  output logic [ID_WIDTH-1:0]                wb_id,
  input  logic                               wb_ack,
  input  logic                               int_accepted,
  input  logic [4:0]                         int_fflags,
  output logic [4:0]                         fflags
);

  localparam int PTR_W = $clog2(NUM_WB_UNITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  // FIFO control state
  logic [CW-1:0]           count_q, count_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic                    wb_done_q, wb_done_d;

  // FIFO storage (data only, never reset)
  logic [DATA_WIDTH-1:0]   rd_mem_q [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]     id_mem_q [FIFO_DEPTH];
  logic [4:0]              ff_mem_q [FIFO_DEPTH];

  logic                    full;
  logic                    pop;
  logic                    space;
  logic                    push;
  logic                    grant_vld;
  logic [PTR_W-1:0]        grant_idx;
  logic [DATA_WIDTH-1:0]   push_rd;
  logic [ID_WIDTH-1:0]     push_id;
  logic [4:0]              push_ff;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = wb_done_q & wb_ack;
  assign space = ~full | pop;

  // No grant during reset so nothing is consumed from a producer and lost.
  assign grant_vld = ~rst & space & (|unit_done);
  assign push      = grant_vld;

`ifdef FP_WB_ROUND_ROBIN_EN
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_WB_UNITS-1:0] upper_req;

  // Round-robin pick: first requester at or above rr_ptr, else the first one below it.
  always_comb begin
    upper_req = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_WB_UNITS; i++) begin
      upper_req[i] = unit_done[i] & (PTR_W'(i) >= rr_ptr_q);
    end
    for (int i = NUM_WB_UNITS - 1; i >= 0; i--) begin
      if (unit_done[i]) grant_idx = PTR_W'(i);
    end
    for (int i = NUM_WB_UNITS - 1; i >= 0; i--) begin
      if (upper_req[i]) grant_idx = PTR_W'(i);
    end
  end

  // Pointer moves just past the winner; holds when nothing is granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      if (grant_idx == PTR_W'(NUM_WB_UNITS - 1)) rr_ptr_d = '0;
      else                                        rr_ptr_d = grant_idx + PTR_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  // Fixed priority pick: lowest requesting index wins.
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_WB_UNITS - 1; i >= 0; i--) begin
      if (unit_done[i]) grant_idx = PTR_W'(i);
    end
  end
`endif

  // One-hot acknowledge and mux of the winning channel's payload.
  always_comb begin
    unit_ack = '0;
    push_rd  = '0;
    push_id  = '0;
    push_ff  = '0;
    for (int i = 0; i < NUM_WB_UNITS; i++) begin
      unit_ack[i] = grant_vld & (grant_idx == PTR_W'(i));
      if (unit_ack[i]) begin
        push_rd = push_rd | unit_rd[i*DATA_WIDTH +: DATA_WIDTH];
        push_id = push_id | unit_id[i*ID_WIDTH +: ID_WIDTH];
        push_ff = push_ff | unit_fflags[i*5 +: 5];
      end
    end
  end

  // Next-state for occupancy and pointers; pointers wrap naturally (power-of-two depth).
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    wb_done_d = (count_d != '0);
  end

  // FIFO control registers; reset drops any buffered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wb_done_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wb_done_q <= wb_done_d;
    end
  end

  // Write the granted result at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q] <= push_rd;
      id_mem_q[wr_ptr_q] <= push_id;
      ff_mem_q[wr_ptr_q] <= push_ff;
    end
  end

  assign wb_done = wb_done_q;
  assign wb_rd   = rd_mem_q[rd_ptr_q];
  assign wb_id   = id_mem_q[rd_ptr_q];

  // Flags reported to fcsr: popped FP head and/or the integer-path writeback.
  always_comb begin
    fflags = '0;
    if (pop)          fflags = fflags | ff_mem_q[rd_ptr_q];
    if (int_accepted) fflags = fflags | int_fflags;
  end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Testbench for fp_wb_arbiter: directed steps, queue-based reference model of
// the arbiter and FIFO, plus explicit checks of the key scenarios.
module tb_fp_wb_arbiter;
  localparam int N     = 4;
  localparam int DW    = 64;
  localparam int IW    = 3;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    unit_done;
  logic [N*DW-1:0] unit_rd;
  logic [N*IW-1:0] unit_id;
  logic [N*5-1:0]  unit_fflags;
  logic [N-1:0]    unit_ack;
  logic            wb_done;
  logic [DW-1:0]   wb_rd;
  logic [IW-1:0]   wb_id;
  logic            wb_ack;
  logic            int_accepted;
  logic [4:0]      int_fflags;
  logic [4:0]      fflags;

  logic [DW-1:0]   ch_rd [N];
  logic [IW-1:0]   ch_id [N];
  logic [4:0]      ch_ff [N];

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign unit_rd[i*DW +: DW]    = ch_rd[i];
    assign unit_id[i*IW +: IW]    = ch_id[i];
    assign unit_fflags[i*5 +: 5]  = ch_ff[i];
  end

  fp_wb_arbiter #(
    .NUM_WB_UNITS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .unit_done(unit_done), .unit_rd(unit_rd), .unit_id(unit_id),
    .unit_fflags(unit_fflags), .unit_ack(unit_ack),
    .wb_done(wb_done), .wb_rd(wb_rd), .wb_id(wb_id), .wb_ack(wb_ack),
    .int_accepted(int_accepted), .int_fflags(int_fflags), .fflags(fflags)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] rd;
    logic [4:0]    ff;
  } ent_t;

  ent_t          q[$];
  int            errors = 0;
  int            checks = 0;
  int            rr = 0;
  bit            keep_req = 0;
  int            id_limit = 8;
  logic [N-1:0]  ack_log[$];
  int            pop_log[$];
  logic [N-1:0]  obs_ack;
  logic          obs_done;
  logic [IW-1:0] obs_id;
  logic [4:0]    obs_ff;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model at negedge, advance the model,
  // then let producers react to their acknowledge just after the posedge.
  task automatic cycle();
    bit           fp_acc;
    bit           space;
    int           g;
    int           c;
    logic [N-1:0] exp_ack;
    logic [4:0]   exp_ff;
    ent_t         e;
    @(negedge clk);
    obs_ack  = unit_ack;
    obs_done = wb_done;
    obs_id   = wb_id;
    obs_ff   = fflags;
    ack_log.push_back(unit_ack);
    fp_acc = (q.size() > 0) && wb_ack;
    exp_ff = int_accepted ? int_fflags : 5'b0;
    if (fp_acc) exp_ff = exp_ff | q[0].ff;
    space = (q.size() < DEPTH) || fp_acc;
    g = -1;
    if (!rst && space) begin
      for (int k = 0; k < N; k++) begin
`ifdef FP_WB_ROUND_ROBIN_EN
        c = (rr + k) % N;
`else
        c = k;
`endif
        if (g < 0 && unit_done[c]) g = c;
      end
    end
    exp_ack = '0;
    if (g >= 0) exp_ack[g] = 1'b1;
    chk("unit_ack", unit_ack, exp_ack);
    chk("wb_done", wb_done, q.size() > 0);
    if (q.size() > 0) begin
      chk("wb_id", wb_id, q[0].id);
      chk("wb_rd", wb_rd, q[0].rd);
    end
    chk("fflags", fflags, exp_ff);
    if (rst) begin
      q.delete();
      rr = 0;
    end else begin
      if (fp_acc) begin
        pop_log.push_back(int'(wb_id));
        void'(q.pop_front());
      end
      if (g >= 0) begin
        e.id = ch_id[g];
        e.rd = ch_rd[g];
        e.ff = ch_ff[g];
        q.push_back(e);
        rr = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    if (!rst && g >= 0) begin
      if (keep_req && (int'(ch_id[g]) + 1 != id_limit)) begin
        ch_id[g] = ch_id[g] + 1'b1;
        ch_rd[g] = ch_rd[g] + 64'd1;
      end else begin
        unit_done[g] = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp[5];
    rst          = 1'b1;
    unit_done    = 4'b1111;
    wb_ack       = 1'b0;
    int_accepted = 1'b0;
    int_fflags   = 5'b0;
    for (int i = 0; i < N; i++) begin
      ch_rd[i] = 64'h1000 + 64'(i);
      ch_id[i] = IW'(i);
      ch_ff[i] = 5'b0;
    end
    @(posedge clk);
    #1;

    // Reset held while every channel requests
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("reset_ack", obs_ack, 4'b0000);
      chk("reset_done", obs_done, 1'b0);
      chk("reset_ff", obs_ff, 5'b0);
    end

    // Fairness with all channels requesting and writeback always ready
    rst      = 1'b0;
    wb_ack   = 1'b1;
    keep_req = 1'b1;
    ack_log.delete();
    repeat (5) cycle();
    unit_done = '0;
    keep_req  = 1'b0;
`ifdef FP_WB_ROUND_ROBIN_EN
    rr_exp = '{0, 1, 2, 3, 0};
`else
    rr_exp = '{0, 0, 0, 0, 0};
`endif
    for (int k = 0; k < 5; k++) chk("arb_seq", ack_log[k], 4'b0001 << rr_exp[k]);
    repeat (2) cycle();

    // Single result on channel 2
    ch_rd[2]  = 64'h4000_0000_0000_0000;
    ch_id[2]  = 3'd5;
    ch_ff[2]  = 5'b00001;
    unit_done = 4'b0100;
    cycle();
    chk("single_ack", obs_ack, 4'b0100);
    cycle();
    chk("single_done", obs_done, 1'b1);
    chk("single_id", obs_id, 3'd5);
    chk("single_ff", obs_ff, 5'b00001);
    cycle();
    chk("single_empty", obs_done, 1'b0);

    // Full FIFO and backpressure
    wb_ack    = 1'b0;
    keep_req  = 1'b1;
    ch_id[0]  = 3'd1;
    ch_id[1]  = 3'd2;
    unit_done = 4'b0011;
    cycle();
    cycle();
    cycle();
    chk("full_no_ack", obs_ack, 4'b0000);
    wb_ack = 1'b1;
    cycle();
    chk("full_pop_grant", $countones(obs_ack), 1);
    chk("full_pop_done", obs_done, 1'b1);
    wb_ack = 1'b0;
    cycle();
    chk("still_full", obs_ack, 4'b0000);
    keep_req  = 1'b0;
    unit_done = '0;
    wb_ack    = 1'b1;
    repeat (3) cycle();

    // Flag merge with the integer path
    ch_id[1]  = 3'd6;
    ch_ff[1]  = 5'b10000;
    unit_done = 4'b0010;
    wb_ack    = 1'b0;
    cycle();
    wb_ack       = 1'b1;
    int_accepted = 1'b1;
    int_fflags   = 5'b00101;
    cycle();
    chk("merge_ff", obs_ff, 5'b10101);
    cycle();
    chk("int_only_ff", obs_ff, 5'b00101);
    int_accepted = 1'b0;
    cycle();
    chk("none_ff", obs_ff, 5'b00000);

    // Wrap-around: IDs 0..6 through the depth-2 FIFO under random wb_ack
    ch_id[0]  = 3'd0;
    ch_rd[0]  = 64'h100;
    ch_ff[0]  = 5'b0;
    keep_req  = 1'b1;
    id_limit  = 7;
    pop_log.delete();
    unit_done = 4'b0001;
    for (int n = 0; n < 200 && pop_log.size() < 7; n++) begin
      wb_ack = 1'($urandom_range(0, 1));
      cycle();
    end
    chk("wrap_count", pop_log.size(), 7);
    for (int k = 0; k < 7 && k < pop_log.size(); k++) chk("wrap_order", pop_log[k], k);
    id_limit  = 8;
    keep_req  = 1'b0;
    unit_done = '0;
    wb_ack    = 1'b1;
    repeat (3) cycle();

    // Reset in the middle of operation with a full FIFO
    wb_ack    = 1'b0;
    keep_req  = 1'b1;
    unit_done = 4'b0011;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("midrst_ack", obs_ack, 4'b0000);
    rst       = 1'b0;
    keep_req  = 1'b0;
    unit_done = '0;
    cycle();
    chk("midrst_done", obs_done, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
